// File: rtl/ipg_pkg.sv
// Shared definitions for the IPG transmit framer and the receive-side processor:
// state encoding, header layout, slot cap and field/counter widths.
package ipg_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HDR     = 2'd1,
        ADDR    = 2'd2,
        PAYLOAD = 2'd3
    } ipg_state_e;

    localparam int HDR_OPCODE_BIT = 0;
    localparam int HDR_BITS       = 8;
    localparam int ADDR_BITS      = 64;
    localparam int PAYLOAD_BITS   = 512;
    localparam int SLOT_CAP       = 56;
    localparam int ADDR_CNT_W     = 7;
    localparam int PAY_CNT_W      = 10;
    localparam int LEN_W          = 6;

    // Usable slot: offered IPG bits rounded down to whole bytes, capped at SLOT_CAP.
    function automatic logic [LEN_W-1:0] eff_slot(input logic [LEN_W-1:0] avail);
        logic [LEN_W-1:0] s;
        s = avail & 6'h38;
        return (s > 6'(SLOT_CAP)) ? 6'(SLOT_CAP) : s;
    endfunction

endpackage

// File: rtl/ipg_chunk_select.sv
// Combinational chunk extractor: returns field[count +: len], LSB-aligned,
// with every bit above len forced to zero.
module ipg_chunk_select
    import ipg_pkg::*;
#(
    parameter int FIELD_WIDTH = 512,
    parameter int DATA_WIDTH  = 64,
    parameter int CNT_WIDTH   = 10,
    parameter int LEN_WIDTH   = 6
) (
    input  logic [FIELD_WIDTH-1:0] field,
    input  logic [CNT_WIDTH-1:0]   count,
    input  logic [LEN_WIDTH-1:0]   len,
    output logic [DATA_WIDTH-1:0]  data
);

    logic [DATA_WIDTH-1:0] mask_s;

    assign mask_s = ~({DATA_WIDTH{1'b1}} << len);
    assign data   = DATA_WIDTH'(field >> count) & mask_s;

endmodule

// File: rtl/ipg_tx_framer.sv
// Serializes a captured read/write request (header, address, optional payload)
// into the inter-packet-gap bits offered by the PHY each cycle.
module ipg_tx_framer
    import ipg_pkg::*;
#(
    parameter int DATA_WIDTH    = 64,
    parameter int HDR_WIDTH     = 8,
    parameter int ADDR_WIDTH    = 64,
    parameter int PAYLOAD_WIDTH = 512
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [ADDR_WIDTH-1:0]    req_addr,
    input  logic [PAYLOAD_WIDTH-1:0] req_payload,
    input  logic [5:0]               tx_ipg_avail,
    output logic [DATA_WIDTH-1:0]    tx_ipg_data,
    output logic [5:0]               tx_ipg_len,
    output logic                     tx_done
);

    ipg_state_e               state_r, state_nxt_s;
    logic                     write_r;
    logic [ADDR_WIDTH-1:0]    addr_r;
    logic [PAYLOAD_WIDTH-1:0] payload_r;
    logic [ADDR_CNT_W-1:0]    addr_cnt_r, addr_cnt_nxt_s, addr_rem_s;
    logic [PAY_CNT_W-1:0]     pay_cnt_r, pay_cnt_nxt_s, pay_rem_s;
    logic [LEN_W-1:0]         slot_s, len_s;
    logic [PAYLOAD_WIDTH-1:0] field_s;
    logic [PAY_CNT_W-1:0]     count_s;
    logic [HDR_WIDTH-1:0]     hdr_s;
    logic [DATA_WIDTH-1:0]    chunk_s;
    logic                     ready_s, done_s;

    assign slot_s     = eff_slot(tx_ipg_avail);
    assign addr_rem_s = ADDR_CNT_W'(ADDR_WIDTH) - addr_cnt_r;
    assign pay_rem_s  = PAY_CNT_W'(PAYLOAD_WIDTH) - pay_cnt_r;

    // Header image: opcode bit carries the write flag, all other bits zero.
    always_comb begin
        hdr_s                 = {HDR_WIDTH{1'b0}};
        hdr_s[HDR_OPCODE_BIT] = write_r;
    end

    // Next-state, chunk length and field selection; a zero slot stalls everything.
    always_comb begin
        state_nxt_s    = state_r;
        addr_cnt_nxt_s = addr_cnt_r;
        pay_cnt_nxt_s  = pay_cnt_r;
        len_s          = 6'd0;
        field_s        = {PAYLOAD_WIDTH{1'b0}};
        count_s        = 10'd0;
        ready_s        = 1'b0;
        done_s         = 1'b0;
        case (state_r)
            IDLE: begin
                ready_s = 1'b1;
                if (req_valid) state_nxt_s = HDR;
                else           state_nxt_s = IDLE;
            end
            HDR: begin
                field_s = PAYLOAD_WIDTH'(hdr_s);
                if (slot_s >= 6'(HDR_WIDTH)) begin
                    len_s       = 6'(HDR_WIDTH);
                    state_nxt_s = ADDR;
                end else begin
                    state_nxt_s = HDR;
                end
            end
            ADDR: begin
                field_s = PAYLOAD_WIDTH'(addr_r);
                count_s = PAY_CNT_W'(addr_cnt_r);
                if ({1'b0, slot_s} <= addr_rem_s) len_s = slot_s;
                else                              len_s = addr_rem_s[LEN_W-1:0];
                if ({1'b0, len_s} == addr_rem_s) begin
                    addr_cnt_nxt_s = 7'd0;
                    if (write_r) begin
                        state_nxt_s = PAYLOAD;
                    end else begin
                        state_nxt_s = IDLE;
                        done_s      = 1'b1;
                    end
                end else begin
                    addr_cnt_nxt_s = addr_cnt_r + {1'b0, len_s};
                end
            end
            PAYLOAD: begin
                field_s = payload_r;
                count_s = pay_cnt_r;
                if ({4'd0, slot_s} <= pay_rem_s) len_s = slot_s;
                else                             len_s = pay_rem_s[LEN_W-1:0];
                if ({4'd0, len_s} == pay_rem_s) begin
                    pay_cnt_nxt_s = 10'd0;
                    state_nxt_s   = IDLE;
                    done_s        = 1'b1;
                end else begin
                    pay_cnt_nxt_s = pay_cnt_r + {4'd0, len_s};
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    ipg_chunk_select #(
        .FIELD_WIDTH (PAYLOAD_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH),
        .CNT_WIDTH   (PAY_CNT_W),
        .LEN_WIDTH   (LEN_W)
    ) u_chunk_select (
        .field (field_s),
        .count (count_s),
        .len   (len_s),
        .data  (chunk_s)
    );

    // Outputs are forced quiet for as long as reset is held.
    assign req_ready   = ready_s & ~rst;
    assign tx_ipg_len  = rst ? 6'd0 : len_s;
    assign tx_ipg_data = rst ? {DATA_WIDTH{1'b0}} : chunk_s;
    assign tx_done     = done_s & ~rst;

    // State, field counters and request capture registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            addr_cnt_r <= 7'd0;
            pay_cnt_r  <= 10'd0;
            write_r    <= 1'b0;
            addr_r     <= {ADDR_WIDTH{1'b0}};
            payload_r  <= {PAYLOAD_WIDTH{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            addr_cnt_r <= addr_cnt_nxt_s;
            pay_cnt_r  <= pay_cnt_nxt_s;
            if (ready_s && req_valid) begin
                write_r   <= req_write;
                addr_r    <= req_addr;
                payload_r <= req_payload;
            end else begin
                write_r   <= write_r;
                addr_r    <= addr_r;
                payload_r <= payload_r;
            end
        end
    end

endmodule

// File: tb/tb_ipg_tx_framer.sv
// Randomized bench for ipg_tx_framer: a field-queue reference model predicts every
// chunk, and a receiver rebuilds each request from the observed chunks.
module tb_ipg_tx_framer;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic         req_write;
    logic [63:0]  req_addr;
    logic [511:0] req_payload;
    logic [5:0]   tx_ipg_avail;
    logic [63:0]  tx_ipg_data;
    logic [5:0]   tx_ipg_len;
    logic         tx_done;

    ipg_tx_framer #(
        .DATA_WIDTH    (64),
        .HDR_WIDTH     (8),
        .ADDR_WIDTH    (64),
        .PAYLOAD_WIDTH (512)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_payload  (req_payload),
        .tx_ipg_avail (tx_ipg_avail),
        .tx_ipg_data  (tx_ipg_data),
        .tx_ipg_len   (tx_ipg_len),
        .tx_done      (tx_done)
    );

    always #5 clk = ~clk;

    int n_tests   = 0;
    int n_fail    = 0;
    int cyc_g     = 0;
    int chunk_obs = 0;
    int obs_len_g = 0;

    // Reference model: a request is a list of fields sent in order, LSB-first.
    bit           busy = 1'b0;
    int           nf, fi, cons;
    int           fwid [3];
    logic [511:0] fval [3];
    logic [511:0] rxf  [3];

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_g);
        end
    endtask

    function automatic logic [5:0] pick_avail(input int mode, input int k);
        case (mode)
            0:       return 6'd56;
            1:       return (k % 2 == 0) ? 6'd0 : 6'd24;
            2:       return 6'($urandom_range(0, 63));
            3:       return (k % 2 == 0) ? 6'd20 : 6'd63;
            default: return 6'd56;
        endcase
    endfunction

    function automatic logic [511:0] rnd512();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // One clock: compare outputs against the model, advance the model, move to next negedge.
    task automatic tick(output bit acc, output bit dn);
        int s, rem, len_e;
        logic [511:0] data_e;
        bit done_e, ready_e;
        #1;
        acc = 1'b0; dn = 1'b0;
        s = (int'(tx_ipg_avail) / 8) * 8;
        if (s > 56) s = 56;
        len_e = 0; data_e = '0; done_e = 1'b0;
        ready_e = !busy && !rst;
        if (busy && !rst) begin
            rem = fwid[fi] - cons;
            if (fi == 0) len_e = (s >= 8) ? 8 : 0;
            else         len_e = (s < rem) ? s : rem;
            data_e = (fval[fi] >> cons) & ((512'd1 << len_e) - 512'd1);
            done_e = (fi == nf - 1) && (len_e != 0) && (cons + len_e == fwid[fi]);
        end
        check_eq("req_ready",   512'(req_ready),   512'(ready_e));
        check_eq("tx_ipg_len",  512'(tx_ipg_len),  512'(len_e));
        check_eq("tx_ipg_data", 512'(tx_ipg_data), data_e);
        check_eq("tx_done",     512'(tx_done),     512'(done_e));
        obs_len_g = int'(tx_ipg_len);
        if (tx_ipg_len != 6'd0) chunk_obs++;
        if (rst) begin
            busy = 1'b0;
        end else if (busy) begin
            for (int b = 0; b < int'(tx_ipg_len); b++)
                if (cons + b < 512) rxf[fi][cons + b] = tx_ipg_data[b];
            cons += len_e;
            if (cons >= fwid[fi]) begin
                fi++;
                cons = 0;
            end
            if (fi >= nf) begin
                busy = 1'b0;
                dn   = 1'b1;
                check_eq("rx_hdr",  rxf[0], fval[0]);
                check_eq("rx_addr", rxf[1], fval[1]);
                if (nf == 3) check_eq("rx_payload", rxf[2], fval[2]);
            end
        end else if (req_valid) begin
            acc = 1'b1; busy = 1'b1; fi = 0; cons = 0;
            fval[0] = {511'd0, req_write};  fwid[0] = 8;
            fval[1] = {448'd0, req_addr};   fwid[1] = 64;
            fval[2] = req_payload;          fwid[2] = 512;
            nf = req_write ? 3 : 2;
            for (int k = 0; k < 3; k++) rxf[k] = '0;
        end
        cyc_g++;
        @(negedge clk);
    endtask

    task automatic run_req(input string name, input bit w, input logic [63:0] a,
                           input logic [511:0] p, input int mode, input int n_exp,
                           input int abort_after);
        bit acc, dn, fin;
        int k, dones;
        fin = 1'b0; k = 0; dones = 0; chunk_obs = 0;
        req_write = w; req_addr = a; req_payload = p; req_valid = 1'b1;
        while (!fin && k < 3000) begin
            tx_ipg_avail = pick_avail(mode, k);
            tick(acc, dn);
            if (acc) req_valid = 1'b0;
            if (dn) begin
                dones++;
                fin = 1'b1;
            end
            if (abort_after > 0 && chunk_obs >= abort_after) k = 3000;
            else k++;
        end
        req_valid = 1'b0;
        if (abort_after > 0) begin
            check_eq({name, "_no_done"}, 512'(dones), 512'd0);
            rst = 1'b1;
            tick(acc, dn);
            tick(acc, dn);
            rst = 1'b0;
        end else begin
            check_eq({name, "_finished"}, 512'(fin), 512'd1);
            if (n_exp > 0) check_eq({name, "_chunks"}, 512'(chunk_obs), 512'(n_exp));
        end
    endtask

    initial begin
        bit acc, dn;
        int accepted, dones, done_cyc, hdr_cyc, k;

        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_payload = '0; tx_ipg_avail = 6'd56;
        @(negedge clk);
        tick(acc, dn);
        req_valid = 1'b1; req_write = 1'b1;
        tick(acc, dn);
        req_valid = 1'b0;
        tick(acc, dn);
        rst = 1'b0;

        run_req("wr56", 1'b1, 64'h1122334455667700, {64{8'hAB}}, 0, 13, 0);
        run_req("rd56", 1'b0, 64'h00AABB12332155DD, rnd512(), 0, 3, 0);
        tick(acc, dn);
        run_req("rd_alt", 1'b0, {$urandom, $urandom}, rnd512(), 1, 4, 0);
        run_req("wr_20_63", 1'b1, {$urandom, $urandom}, rnd512(), 3, 0, 0);
        run_req("wr_abort", 1'b1, {$urandom, $urandom}, rnd512(), 0, 0, 6);
        run_req("rd_after_rst", 1'b0, {$urandom, $urandom}, rnd512(), 0, 3, 0);

        // Back-to-back writes with req_valid held high throughout.
        accepted = 0; dones = 0; done_cyc = -100; hdr_cyc = -1; k = 0;
        req_write = 1'b1; req_addr = {$urandom, $urandom}; req_payload = rnd512();
        req_valid = 1'b1; tx_ipg_avail = 6'd56;
        while (dones < 2 && k < 3000) begin
            tick(acc, dn);
            if (accepted == 2 && hdr_cyc < 0 && obs_len_g != 0) hdr_cyc = cyc_g - 1;
            if (acc) begin
                accepted++;
                if (accepted == 1) begin
                    req_addr = {$urandom, $urandom};
                    req_payload = rnd512();
                end else begin
                    req_valid = 1'b0;
                end
            end
            if (dn) begin
                dones++;
                if (dones == 1) done_cyc = cyc_g - 1;
            end
            k++;
        end
        req_valid = 1'b0;
        check_eq("b2b_dones", 512'(dones), 512'd2);
        check_eq("b2b_hdr_gap", 512'(hdr_cyc - done_cyc), 512'd2);

        // Random requests, random gaps and random IPG availability.
        for (int r = 0; r < 20; r++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                tx_ipg_avail = 6'($urandom_range(0, 63));
                tick(acc, dn);
            end
            run_req("rand", 1'($urandom_range(0, 1)), {$urandom, $urandom}, rnd512(), 2, 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ipg_tx_framer.md
IPG_TX_FRAMER -- requirements
Module: ipg_tx_framer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64: width of one IPG chunk.
REQ-002 SHALL have parameter HDR_WIDTH, default 8: request header width.
REQ-003 SHALL have parameter ADDR_WIDTH, default 64: address field width.
REQ-004 SHALL have parameter PAYLOAD_WIDTH, default 512: write payload width.
REQ-005 SHALL have port clk, input, 1: the single clock.
REQ-006 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port req_valid, input, 1: request offered.
REQ-008 SHALL have port req_ready, output, 1: framer accepts a request.
REQ-009 SHALL have port req_write, input, 1: 1 = write request, 0 = read request.
REQ-010 SHALL have port req_addr, input, ADDR_WIDTH: target address.
REQ-011 SHALL have port req_payload, input, PAYLOAD_WIDTH: write data (ignored for reads).
REQ-012 SHALL have port tx_ipg_avail, input, 6: IPG bits offered by the PHY this cycle.
REQ-013 SHALL have port tx_ipg_data, output, DATA_WIDTH: chunk bits, LSB-aligned.
REQ-014 SHALL have port tx_ipg_len, output, 6: bits of tx_ipg_data consumed this cycle.
REQ-015 SHALL have port tx_done, output, 1: one-cycle pulse on the final chunk of a request.

Function
REQ-016 SHALL use states IDLE, HDR, ADDR, PAYLOAD.
REQ-017 SHALL assert req_ready only in IDLE; transfer = req_valid && req_ready; a transfer SHALL capture req_write, req_addr and req_payload into registers and go to HDR.
REQ-018 SHALL compute effective slot = min(tx_ipg_avail rounded down to a multiple of 8, 56); for example, 20 -> 16 and 63 -> 56.
REQ-019 SHALL drive tx_ipg_data and tx_ipg_len combinationally from registered state plus tx_ipg_avail, with zero-cycle latency.
REQ-020 SHALL set chunk length = min(effective slot, bits remaining in the current field); a chunk never spans two fields.
REQ-021 SHALL place the header in the HDR chunk as follows: bit0 = req_write, remaining bits 0.
REQ-022 SHALL send the HDR state as exactly one 8-bit chunk when the effective slot is 8 or more.
REQ-023 SHALL serialize the address and payload fields LSB-first; the chunk carries field bits [count +: len] and unused upper bits of tx_ipg_data are 0.
REQ-024 SHALL use an address counter that is 7 bits wide and a payload counter that is 10 bits wide; each advances by tx_ipg_len on each clock edge.
REQ-025 SHALL, when the effective slot is 0, drive tx_ipg_len = 0 and tx_ipg_data = 0, and leave state and counters unchanged (stall).
REQ-026 SHALL make the following transitions: HDR -> ADDR; ADDR -> PAYLOAD when the counter reaches 64 and the request is a write; ADDR -> IDLE when the counter reaches 64 and the request is a read; PAYLOAD -> IDLE when the counter reaches 512.
REQ-027 SHALL pulse tx_done in the same cycle as the final chunk, and SHALL clear both counters on leaving the field.
REQ-028 SHALL drive tx_ipg_len = 0 and tx_ipg_data = 0 in IDLE, and SHALL ignore tx_ipg_avail in IDLE.
REQ-029 SHALL allow back-to-back requests: a new request is accepted in the IDLE cycle after tx_done, and its HDR chunk is sent no earlier than the following cycle.

Reset
REQ-030 SHALL, while rst is high, force IDLE, clear both counters and all captured registers, and drive req_ready=0, tx_ipg_len=0, tx_ipg_data=0, tx_done=0.
REQ-031 SHALL treat rst asserted mid-request as an abort: the partial request is discarded with no tx_done, and req_ready=1 in the first cycle after rst falls.

Structure
REQ-032 SHALL define the state encoding, header bit positions (opcode bit0), the 56-bit slot cap, and the field widths in a shared package ipg_pkg, which is also used by the receive-side processor.
REQ-033 SHALL instantiate one sub-module, ipg_chunk_select, which is combinational and selects field[count +: len] with masking.

Verification
REQ-034 SHALL cover this scenario: a write request with addr=0x1122334455667700, payload pattern 0xAB.., and avail=56 every cycle -> 13 chunks with lengths 8, 56, 8, then nine of 56 and one of 8; tx_done on the 13th.
REQ-035 SHALL cover this scenario: a read request with addr=0xAABB12332155DD and avail=56 -> 3 chunks with lengths 8, 56, 8; header chunk = 0x00; req_ready=1 in the next cycle.
REQ-036 SHALL cover this scenario: during ADDR, avail alternating 0 and 24 -> outputs 0 on zero-avail cycles; 24-bit chunks otherwise; the address is reassembled exactly after 64 bits.
REQ-037 SHALL cover this scenario: avail=20, then 63 -> lengths 16 and 56 respectively.
REQ-038 SHALL cover this scenario: rst pulsed after 3 payload chunks -> no tx_done; a following read request frames correctly from HDR.
REQ-039 SHALL cover this scenario: two back-to-back writes with req_valid held high -> second header follows the first tx_done by 2 cycles; the receive-side processor reassembles both payloads bit-exact.
